iter_fft_mem_ctrl: RTL and testbench
====================================

Name: iter_fft_mem_ctrl

Overview:
- Sequencer for the iterative radix-2 DIT FFT core, built around a pair of dual-port RAM banks used ping-pong.
- Per stage: reads every butterfly operand pair from the source bank on ports A/B, generates the twiddle address, and writes results to the same addresses in the other bank after a fixed pipeline latency.
- Swaps banks every stage and signals completion after the last stage.
- Input data is already in bit-reversed order in bank 0.

Parameters:
- AWL, 8, RAM address width; transform size N = 2^AWL; butterflies per stage = N/2; stages = AWL.
- PIPE_LAT, 4, cycles from read issue (o_RD_EN high) to write-back of that butterfly; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  synchronous reset, active low.
- i_START  in  1  start request; sampled only in IDLE.
- o_BUSY  out  1  high from the cycle after accepted i_START until o_DONE.
- o_DONE  out  1  one-cycle pulse after the final write of the final stage.
- o_STAGE  out  $clog2(AWL)+1  current stage index.
- o_RD_EN  out  1  read strobe to both ports of the source bank.
- o_RD_BANK  out  1  source bank select.
- o_RD_ADDR_A  out  AWL  upper-leg operand address.
- o_RD_ADDR_B  out  AWL  lower-leg operand address.
- o_TW_ADDR  out  AWL-1  twiddle ROM address, aligned with o_RD_EN.
- o_WR_EN  out  1  write strobe to both ports of the destination bank.
- o_WR_BANK  out  1  destination bank select.
- o_WR_ADDR_A  out  AWL  write address, port A.
- o_WR_ADDR_B  out  AWL  write address, port B.
- o_RES_BANK  out  1  bank holding the final result (AWL mod 2); valid when o_DONE pulses and held until next start.

Behaviour:
- Reset (RSTn=0 at a rising edge): state IDLE. All outputs 0, including the write delay line, counters and bank.
- All outputs are registered.
- FSM states:
  - IDLE -> READ on i_START=1. Next cycle: stage=0, k=0, o_BUSY=1.
  - READ: o_RD_EN=1 every cycle; k increments 0..N/2-1. After k=N/2-1 -> DRAIN.
  - DRAIN: lasts exactly PIPE_LAT cycles, o_RD_EN=0. At the end:
    - if stage<AWL-1: stage+1, o_RD_BANK toggles, k=0 -> READ;
    - else -> DONE.
  - DONE: one cycle; o_DONE=1, o_BUSY=0 -> IDLE.
- Address generation for stage s, butterfly k:
  - span = 2^s, pos = k mod span, grp = k >> s
  - o_RD_ADDR_A = (grp << (s+1)) | pos
  - o_RD_ADDR_B = o_RD_ADDR_A + span (never overflows AWL bits)
  - o_TW_ADDR = pos << (AWL-1-s)
- Write path: a PIPE_LAT-deep delay line of {RD_EN, ADDR_A, ADDR_B, bank}.
  - o_WR_EN, o_WR_ADDR_A and o_WR_ADDR_B equal the read values from PIPE_LAT cycles earlier.
  - o_WR_BANK = ~(delayed o_RD_BANK).
- Timing:
  - Last read at cycle T, last write at T+PIPE_LAT, next stage's first read at T+PIPE_LAT+1. There is no read/write overlap across stages.
  - Total from first read to o_DONE = AWL*(N/2+PIPE_LAT) cycles; o_DONE falls in the cycle after the final write.
- Read and write of different stages never target the same bank in the same cycle.
- i_START while busy or in DONE is ignored (no queueing).
- Reset mid-operation: abort immediately; delay line flushed, so no further o_WR_EN. RAM contents are undefined to the datapath.
- i_START held high continuously: a new run begins in the cycle after DONE returns to IDLE.

Test Plan:
- Reset: AWL=3, PIPE_LAT=2, RSTn=0 for 3 cycles with i_START=1 -> all outputs 0. First READ cycle is the 2nd cycle after RSTn rises with i_START held.
- Stage 0 addresses (AWL=3, PIPE_LAT=2): start -> read pairs (0,1),(2,3),(4,5),(6,7), TW 0,0,0,0, o_RD_BANK=0. Writes use the same pairs 2 cycles later with o_WR_BANK=1.
- Stages 1/2 addresses:
  - stage1 -> (0,2)tw0, (1,3)tw2, (4,6)tw0, (5,7)tw2, RD_BANK=1.
  - stage2 -> (0,4)tw0, (1,5)tw1, (2,6)tw2, (3,7)tw3, RD_BANK=0.
- Completion: AWL=3, PIPE_LAT=2 -> o_DONE pulse exactly 18 cycles after the first o_RD_EN, 1 cycle wide, o_RES_BANK=1. AWL=4 -> o_RES_BANK=0, 4*(8+2)=40 cycles.
- Busy ignore: pulse i_START during stage 1 -> no change in address sequence, single o_DONE. i_START held high -> back-to-back runs separated by one IDLE cycle.
- Mid-run reset: assert RSTn=0 during stage 1 DRAIN -> o_WR_EN low from the next cycle. After release and start, the sequence restarts at stage 0, k=0, bank 0.

Source files
------------

// File: rtl/iter_fft_mem_ctrl_if.sv
// iter_fft_mem_ctrl_if: start/status and RAM/twiddle address bundle of the FFT sequencer
interface iter_fft_mem_ctrl_if #(
    parameter int AWL = 8
);
    localparam int SW = $clog2(AWL) + 1;
    logic i_START;
    logic o_BUSY;
    logic o_DONE;
    logic [SW-1:0] o_STAGE;
    logic o_RD_EN;
    logic o_RD_BANK;
    logic [AWL-1:0] o_RD_ADDR_A;
    logic [AWL-1:0] o_RD_ADDR_B;
    logic [AWL-2:0] o_TW_ADDR;
    logic o_WR_EN;
    logic o_WR_BANK;
    logic [AWL-1:0] o_WR_ADDR_A;
    logic [AWL-1:0] o_WR_ADDR_B;
    logic o_RES_BANK;
    modport master (
        input  i_START,
        output o_BUSY, o_DONE, o_STAGE, o_RD_EN, o_RD_BANK, o_RD_ADDR_A, o_RD_ADDR_B,
               o_TW_ADDR, o_WR_EN, o_WR_BANK, o_WR_ADDR_A, o_WR_ADDR_B, o_RES_BANK
    );
    modport slave (
        output i_START,
        input  o_BUSY, o_DONE, o_STAGE, o_RD_EN, o_RD_BANK, o_RD_ADDR_A, o_RD_ADDR_B,
               o_TW_ADDR, o_WR_EN, o_WR_BANK, o_WR_ADDR_A, o_WR_ADDR_B, o_RES_BANK
    );
endinterface

// File: rtl/iter_fft_mem_ctrl.sv
// iter_fft_mem_ctrl: ping-pong bank sequencer for an iterative radix-2 DIT FFT
module iter_fft_mem_ctrl #(
    parameter int AWL = 8,
    parameter int PIPE_LAT = 4
) (
    input logic CLK,
    input logic RSTn,
    iter_fft_mem_ctrl_if.master bus
);
    localparam int SW = $clog2(AWL) + 1;
    localparam int KW = AWL - 1;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [KW-1:0] k, k_n, tw, tw_n;
    logic [SW-1:0] stage, stage_n;
    logic [3:0] cnt, cnt_n;
    logic bank, bank_n, res, res_n, busy, done, rd_en;
    logic [AWL-1:0] rd_a, rd_b, ke, span, mask, lo, a_n;
    logic [PIPE_LAT-1:0] dl_en, dl_bank;
    logic [AWL-1:0] dl_a [PIPE_LAT];
    logic [AWL-1:0] dl_b [PIPE_LAT];
    always_comb begin
        state_n = state;
        k_n = k;
        stage_n = stage;
        cnt_n = cnt;
        bank_n = bank;
        res_n = res;
        case (state)
            IDLE: if (bus.i_START) begin
                state_n = READ;
                k_n = '0;
                stage_n = '0;
                bank_n = 1'b0;
                res_n = 1'b0;
            end
            READ: if (k == '1) begin
                state_n = DRAIN;
                cnt_n = '0;
            end else k_n = k + KW'(1);
            DRAIN: if (cnt != 4'(PIPE_LAT - 1)) cnt_n = cnt + 4'd1;
            else if (stage == SW'(AWL - 1)) begin
                state_n = DONE;
                res_n = 1'(AWL % 2);
            end else begin
                state_n = READ;
                stage_n = stage + SW'(1);
                bank_n = ~bank;
                k_n = '0;
            end
            DONE: state_n = IDLE;
        endcase
        // operand A is k with a zero bit inserted at position stage; B sets that bit
        span = AWL'(1) << stage_n;
        mask = span - AWL'(1);
        ke = AWL'(k_n);
        lo = ke & mask;
        a_n = ((ke & ~mask) << 1) | lo;
        tw_n = KW'(lo << (SW'(KW) - stage_n));
    end
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
            k <= '0;
            stage <= '0;
            cnt <= '0;
            bank <= 1'b0;
            res <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            rd_en <= 1'b0;
            rd_a <= '0;
            rd_b <= '0;
            tw <= '0;
            dl_en <= '0;
            dl_bank <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else begin
            state <= state_n;
            k <= k_n;
            stage <= stage_n;
            cnt <= cnt_n;
            bank <= bank_n;
            res <= res_n;
            busy <= state_n == READ || state_n == DRAIN;
            done <= state_n == DONE;
            rd_en <= state_n == READ;
            if (state_n == READ) begin
                rd_a <= a_n;
                rd_b <= a_n | span;
                tw <= tw_n;
            end
            dl_en <= PIPE_LAT'({dl_en, rd_en});
            dl_bank <= PIPE_LAT'({dl_bank, ~bank});
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
            dl_a[0] <= rd_a;
            dl_b[0] <= rd_b;
        end
    end
    assign bus.o_BUSY = busy;
    assign bus.o_DONE = done;
    assign bus.o_STAGE = stage;
    assign bus.o_RD_EN = rd_en;
    assign bus.o_RD_BANK = bank;
    assign bus.o_RD_ADDR_A = rd_a;
    assign bus.o_RD_ADDR_B = rd_b;
    assign bus.o_TW_ADDR = tw;
    assign bus.o_WR_EN = dl_en[PIPE_LAT-1];
    assign bus.o_WR_BANK = dl_bank[PIPE_LAT-1];
    assign bus.o_WR_ADDR_A = dl_a[PIPE_LAT-1];
    assign bus.o_WR_ADDR_B = dl_b[PIPE_LAT-1];
    assign bus.o_RES_BANK = res;
endmodule

// File: tb/tb_iter_fft_mem_ctrl.sv
// tb_iter_fft_mem_ctrl: directed checks of the FFT bank sequencer at AWL=3 and AWL=4
module tb_iter_fft_mem_ctrl;
    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    int errors = 0;
    int checks = 0;
    // stage-major read schedule for AWL=3: operand A, operand B, twiddle
    int ea [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int eb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int etw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    iter_fft_mem_ctrl_if #(.AWL(3)) b3 ();
    iter_fft_mem_ctrl_if #(.AWL(4)) b4 ();
    iter_fft_mem_ctrl #(.AWL(3), .PIPE_LAT(2)) u3 (.CLK(CLK), .RSTn(RSTn), .bus(b3.master));
    iter_fft_mem_ctrl #(.AWL(4), .PIPE_LAT(2)) u4 (.CLK(CLK), .RSTn(RSTn), .bus(b4.master));

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [23:0] v3;
        logic [28:0] v4;
        RSTn = 1'b0;
        b3.i_START = 1'b1;
        b4.i_START = 1'b0;
        repeat (3) @(negedge CLK);
        v3 = {b3.o_BUSY, b3.o_DONE, b3.o_STAGE, b3.o_RD_EN, b3.o_RD_BANK, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B,
              b3.o_TW_ADDR, b3.o_WR_EN, b3.o_WR_BANK, b3.o_WR_ADDR_A, b3.o_WR_ADDR_B, b3.o_RES_BANK};
        v4 = {b4.o_BUSY, b4.o_DONE, b4.o_STAGE, b4.o_RD_EN, b4.o_RD_BANK, b4.o_RD_ADDR_A, b4.o_RD_ADDR_B,
              b4.o_TW_ADDR, b4.o_WR_EN, b4.o_WR_BANK, b4.o_WR_ADDR_A, b4.o_WR_ADDR_B, b4.o_RES_BANK};
        checks++;
        if (v3 !== '0) begin errors++; $display("FAIL reset_outputs_awl3 got=%h exp=0", v3); end
        checks++;
        if (v4 !== '0) begin errors++; $display("FAIL reset_outputs_awl4 got=%h exp=0", v4); end
        RSTn = 1'b1;
        @(negedge CLK);
        checks++;
        if ({b3.o_RD_EN, b3.o_BUSY, b3.o_STAGE, b3.o_RD_BANK, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B} !== {1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 3'd1})
            begin errors++; $display("FAIL first_read_after_reset got en=%b busy=%b a=%0d b=%0d exp en=1 busy=1 a=0 b=1",
                                     b3.o_RD_EN, b3.o_BUSY, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B); end
        b3.i_START = 1'b0;
        RSTn = 1'b0;
        @(negedge CLK);
        checks++;
        if ({b3.o_RD_EN, b3.o_BUSY} !== 2'b00) begin errors++; $display("FAIL reset_abort got en/busy=%b exp=00", {b3.o_RD_EN, b3.o_BUSY}); end
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (b3.o_WR_EN !== 1'b0) begin errors++; $display("FAIL reset_flush cyc=%0d got wr_en=%b exp=0", i, b3.o_WR_EN); end
        end
    endtask

    task automatic test_addresses();
        int s, j, n;
        logic er, ew;
        b3.i_START = 1'b1;
        @(negedge CLK);
        b3.i_START = 1'b0;
        for (int c = 0; c < 20; c++) begin
            s = c / 6;
            j = c % 6;
            er = c < 18 && j < 4;
            ew = c < 18 && j >= 2;
            checks++;
            if (b3.o_RD_EN !== er) begin errors++; $display("FAIL rd_en c=%0d got=%b exp=%b", c, b3.o_RD_EN, er); end
            if (er) begin
                n = s * 4 + j;
                checks++;
                if ({b3.o_RD_ADDR_A, b3.o_RD_ADDR_B, b3.o_TW_ADDR, b3.o_RD_BANK, b3.o_STAGE} !==
                    {3'(ea[n]), 3'(eb[n]), 2'(etw[n]), 1'(s % 2), 3'(s)})
                    begin errors++; $display("FAIL rd_addr c=%0d got a=%0d b=%0d tw=%0d bank=%b stage=%0d exp a=%0d b=%0d tw=%0d bank=%0d stage=%0d",
                                             c, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B, b3.o_TW_ADDR, b3.o_RD_BANK, b3.o_STAGE,
                                             ea[n], eb[n], etw[n], s % 2, s); end
            end
            checks++;
            if (b3.o_WR_EN !== ew) begin errors++; $display("FAIL wr_en c=%0d got=%b exp=%b", c, b3.o_WR_EN, ew); end
            if (ew) begin
                n = s * 4 + j - 2;
                checks++;
                if ({b3.o_WR_ADDR_A, b3.o_WR_ADDR_B, b3.o_WR_BANK} !== {3'(ea[n]), 3'(eb[n]), 1'(1 - s % 2)})
                    begin errors++; $display("FAIL wr_addr c=%0d got a=%0d b=%0d bank=%b exp a=%0d b=%0d bank=%0d",
                                             c, b3.o_WR_ADDR_A, b3.o_WR_ADDR_B, b3.o_WR_BANK, ea[n], eb[n], 1 - s % 2); end
            end
            checks++;
            if ({b3.o_DONE, b3.o_BUSY} !== {c == 18, c < 18})
                begin errors++; $display("FAIL done_busy c=%0d got=%b%b exp=%b%b", c, b3.o_DONE, b3.o_BUSY, c == 18, c < 18); end
            if (c >= 18) begin
                checks++;
                if (b3.o_RES_BANK !== 1'b1) begin errors++; $display("FAIL res_bank_awl3 c=%0d got=%b exp=1", c, b3.o_RES_BANK); end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_completion_awl4();
        int n = 0;
        b4.i_START = 1'b1;
        @(negedge CLK);
        b4.i_START = 1'b0;
        checks++;
        if ({b4.o_RD_EN, b4.o_RD_ADDR_A, b4.o_RD_ADDR_B} !== {1'b1, 4'd0, 4'd1})
            begin errors++; $display("FAIL awl4_first_read got en=%b a=%0d b=%0d exp en=1 a=0 b=1", b4.o_RD_EN, b4.o_RD_ADDR_A, b4.o_RD_ADDR_B); end
        while (b4.o_DONE !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n !== 40) begin errors++; $display("FAIL awl4_done_latency got=%0d exp=40", n); end
        checks++;
        if ({b4.o_RES_BANK, b4.o_BUSY} !== 2'b00) begin errors++; $display("FAIL awl4_res_busy got=%b exp=00", {b4.o_RES_BANK, b4.o_BUSY}); end
        @(negedge CLK);
        checks++;
        if (b4.o_DONE !== 1'b0) begin errors++; $display("FAIL awl4_done_width got=%b exp=0", b4.o_DONE); end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        int n;
        b3.i_START = 1'b1;
        @(negedge CLK);
        b3.i_START = 1'b0;
        for (int c = 0; c < 26; c++) begin
            if (b3.o_DONE === 1'b1) dones++;
            if (c < 18 && c % 6 < 4) begin
                n = (c / 6) * 4 + c % 6;
                checks++;
                if ({b3.o_RD_EN, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B} !== {1'b1, 3'(ea[n]), 3'(eb[n])})
                    begin errors++; $display("FAIL ignore_rd c=%0d got en=%b a=%0d b=%0d exp en=1 a=%0d b=%0d",
                                             c, b3.o_RD_EN, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B, ea[n], eb[n]); end
            end
            if (c >= 18) begin
                checks++;
                if (b3.o_RD_EN !== 1'b0) begin errors++; $display("FAIL ignore_no_rerun c=%0d got=%b exp=0", c, b3.o_RD_EN); end
            end
            b3.i_START = c == 8;
            @(negedge CLK);
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_back_to_back();
        b3.i_START = 1'b1;
        @(negedge CLK);
        for (int c = 0; c < 40; c++) begin
            if (c == 18) begin
                checks++;
                if (b3.o_DONE !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", b3.o_DONE); end
            end
            if (c == 19) begin
                checks++;
                if ({b3.o_RD_EN, b3.o_BUSY} !== 2'b00) begin errors++; $display("FAIL b2b_idle got=%b exp=00", {b3.o_RD_EN, b3.o_BUSY}); end
            end
            if (c == 20) begin
                checks++;
                if ({b3.o_RD_EN, b3.o_BUSY, b3.o_STAGE, b3.o_RD_BANK, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B} !== {1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 3'd1})
                    begin errors++; $display("FAIL b2b_restart got en=%b stage=%0d bank=%b a=%0d b=%0d exp en=1 stage=0 bank=0 a=0 b=1",
                                             b3.o_RD_EN, b3.o_STAGE, b3.o_RD_BANK, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B); end
                b3.i_START = 1'b0;
            end
            if (c == 38) begin
                checks++;
                if (b3.o_DONE !== 1'b1) begin errors++; $display("FAIL b2b_done2 got=%b exp=1", b3.o_DONE); end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        b3.i_START = 1'b1;
        @(negedge CLK);
        b3.i_START = 1'b0;
        repeat (10) @(negedge CLK);
        checks++;
        if ({b3.o_WR_EN, b3.o_RD_EN, b3.o_STAGE} !== {1'b1, 1'b0, 3'd1})
            begin errors++; $display("FAIL midrst_drain got wr=%b rd=%b stage=%0d exp wr=1 rd=0 stage=1", b3.o_WR_EN, b3.o_RD_EN, b3.o_STAGE); end
        RSTn = 1'b0;
        @(negedge CLK);
        checks++;
        if ({b3.o_WR_EN, b3.o_BUSY, b3.o_STAGE} !== 5'd0) begin errors++; $display("FAIL midrst_abort got wr=%b busy=%b stage=%0d exp 0", b3.o_WR_EN, b3.o_BUSY, b3.o_STAGE); end
        RSTn = 1'b1;
        @(negedge CLK);
        checks++;
        if (b3.o_WR_EN !== 1'b0) begin errors++; $display("FAIL midrst_no_write got=%b exp=0", b3.o_WR_EN); end
        b3.i_START = 1'b1;
        @(negedge CLK);
        b3.i_START = 1'b0;
        checks++;
        if ({b3.o_RD_EN, b3.o_STAGE, b3.o_RD_BANK, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B, b3.o_TW_ADDR} !== {1'b1, 3'd0, 1'b0, 3'd0, 3'd1, 2'd0})
            begin errors++; $display("FAIL midrst_restart got en=%b stage=%0d bank=%b a=%0d b=%0d exp en=1 stage=0 bank=0 a=0 b=1",
                                     b3.o_RD_EN, b3.o_STAGE, b3.o_RD_BANK, b3.o_RD_ADDR_A, b3.o_RD_ADDR_B); end
        while (b3.o_DONE !== 1'b1 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n !== 18) begin errors++; $display("FAIL midrst_done_latency got=%0d exp=18", n); end
        @(negedge CLK);
    endtask

    initial begin
        b3.i_START = 1'b0;
        b4.i_START = 1'b0;
        @(negedge CLK);
        test_reset();
        test_addresses();
        test_completion_awl4();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
